// File: rtl/correlation_frame_packer_if.sv
// Byte-stream and snapshot bundle for the correlation frame packer.
// master: the packer side (takes snapshots, offers bytes).
// slave : the environment side (integrator + UART transmitter).
interface correlation_frame_packer_if #(
  parameter int RESOLUTION = 16,
  parameter int NUM_INPUTS = 8
);
  localparam int NUM_WORDS = NUM_INPUTS + NUM_INPUTS*(NUM_INPUTS-1)/2;

  logic                            snapshot;
  logic [RESOLUTION*NUM_WORDS-1:0] data_in;
  logic [7:0]                      tx_byte;
  logic                            tx_valid;
  logic                            tx_ready;
  logic                            busy;
  logic [7:0]                      overrun_count;

  modport master (
    input  snapshot, data_in, tx_ready,
    output tx_byte, tx_valid, busy, overrun_count
  );

  modport slave (
    output snapshot, data_in, tx_ready,
    input  tx_byte, tx_valid, busy, overrun_count
  );
endinterface

// File: rtl/correlation_frame_packer.sv
// Correlation frame packer: latches a snapshot of all counter words and
// streams it as AA 55 <seq> <data bytes, little-endian per word> [<csum>].
// Optional feature macro: FRAME_CHECKSUM_EN adds the trailing checksum byte
// (mod-256 sum of seq and data bytes) and its CSUM state.
module correlation_frame_packer #(
  parameter int RESOLUTION = 16,
  parameter int NUM_INPUTS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  correlation_frame_packer_if.master bus
);
  localparam int NUM_WORDS = NUM_INPUTS + NUM_INPUTS*(NUM_INPUTS-1)/2;
  localparam int NUM_BYTES = NUM_WORDS*RESOLUTION/8;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES-1);

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, SEQ, DATA, CSUM} state_e;
`else
  typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, SEQ, DATA} state_e;
`endif

  state_e                      state_q, state_d;
  logic [NUM_BYTES-1:0][7:0]   shadow_q, shadow_d;   // byte view: word k byte j sits at k*RES/8+j
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [7:0]                  seq_q, seq_d;
  logic [7:0]                  ovr_q, ovr_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]                  csum_q, csum_d;
`endif
  logic [7:0]                  byte_c;
  logic                        active, xfer;

  // Outputs are pure functions of state, so they hold until the transfer.
  assign active            = (state_q != IDLE);
  assign xfer              = active && bus.tx_ready;
  assign bus.tx_valid      = active;
  assign bus.busy          = active;
  assign bus.tx_byte       = byte_c;
  assign bus.overrun_count = ovr_q;

  // Next-state, byte mux, checksum accumulation and overrun counting.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    seq_d    = seq_q;
    ovr_d    = ovr_q;
`ifdef FRAME_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    byte_c   = 8'h00;
    case (state_q)
      IDLE: begin
        if (bus.snapshot) begin
          shadow_d = bus.data_in;
          idx_d    = '0;
          state_d  = SYNC0;
`ifdef FRAME_CHECKSUM_EN
          csum_d   = 8'h00;
`endif
        end
      end
      SYNC0: begin
        byte_c = 8'hAA;
        if (xfer) state_d = SYNC1;
      end
      SYNC1: begin
        byte_c = 8'h55;
        if (xfer) state_d = SEQ;
      end
      SEQ: begin
        byte_c = seq_q;
        if (xfer) begin
          state_d = DATA;
`ifdef FRAME_CHECKSUM_EN
          csum_d  = csum_q + seq_q;
`endif
        end
      end
      DATA: begin
        byte_c = shadow_q[idx_q];
        if (xfer) begin
`ifdef FRAME_CHECKSUM_EN
          csum_d = csum_q + byte_c;
`endif
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
`ifdef FRAME_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
            seq_d   = seq_q + 8'd1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef FRAME_CHECKSUM_EN
      CSUM: begin
        byte_c = csum_q;
        if (xfer) begin
          state_d = IDLE;
          seq_d   = seq_q + 8'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Any snapshot while a frame is in flight (final-transfer cycle included) is dropped.
    if (active && bus.snapshot && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      seq_q    <= 8'h00;
      ovr_q    <= 8'h00;
`ifdef FRAME_CHECKSUM_EN
      csum_q   <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      ovr_q    <= ovr_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end
endmodule

// File: doc/correlation_frame_packer.md
CORRELATION_FRAME_PACKER -- requirements
Module: correlation_frame_packer

Interface
REQ-001 Parameter RESOLUTION, default 16, sets the bit width of one counter word; it SHALL be a multiple of 8.
REQ-002 Parameter NUM_INPUTS, default 8, sets the number of input lines; NUM_WORDS SHALL equal NUM_INPUTS + NUM_INPUTS*(NUM_INPUTS-1)/2.
REQ-003 Port clk, input, 1 bit, is the single system clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit, is a synchronous active-high reset.
REQ-005 Port snapshot, input, 1 bit, is a one-cycle strobe meaning data_in holds a completed integration.
REQ-006 Port data_in, input, RESOLUTION*NUM_WORDS bits, carries the counter words; word k SHALL occupy bits [k*RESOLUTION +: RESOLUTION].
REQ-007 Port tx_byte, output, 8 bits, is the byte offered to the UART transmitter.
REQ-008 Port tx_valid, output, 1 bit, is high while tx_byte is valid.
REQ-009 Port tx_ready, input, 1 bit, means the transmitter accepts tx_byte in this cycle.
REQ-010 Port busy, output, 1 bit, is high whenever the state is not IDLE.
REQ-011 Port overrun_count, output, 8 bits, counts dropped snapshots and saturates at 255.

Function
REQ-012 The block SHALL use states IDLE, SYNC0, SYNC1, SEQ, DATA and CSUM.
REQ-013 In IDLE, a snapshot SHALL latch all of data_in into a shadow register and move the state to SYNC0 on the next edge.
REQ-014 tx_valid SHALL rise in the cycle after the accepted snapshot, with tx_byte = 0xAA.
REQ-015 A byte transfers only in a cycle where both tx_valid and tx_ready are high; tx_byte and tx_valid SHALL hold unchanged until that transfer.
REQ-016 The frame byte order SHALL be 0xAA (SYNC0), 0x55 (SYNC1), the sequence byte (SEQ), then the DATA bytes.
REQ-017 DATA SHALL send words 0 to NUM_WORDS-1, each little-endian, for RESOLUTION/8 bytes per word.
REQ-018 A byte index counter SHALL advance on each DATA transfer.
REQ-019 After the last DATA transfer, the state SHALL go to CSUM, or to IDLE if the checksum is disabled (REQ-027).
REQ-020 The checksum SHALL be the modulo-256 sum of the sequence byte and all DATA bytes; sync bytes are excluded.
REQ-021 tx_valid SHALL go low in the cycle after the final byte transfers.
REQ-022 The sequence counter SHALL increment by 1 when the final byte of a frame transfers, wrapping from 255 to 0.
REQ-023 A snapshot arriving while busy is high, including in the cycle of the final transfer, SHALL be dropped and SHALL increment overrun_count; at 255 the count holds.
REQ-024 The shadow register SHALL NOT change while busy is high; later data_in changes SHALL NOT affect the frame in flight.
REQ-025 If tx_ready stays low indefinitely, the block SHALL hold its current byte with no timeout.

Reset
REQ-026 When reset is high at a rising edge, whether idle or mid-frame, the block SHALL on that edge set the state to IDLE, tx_valid = 0, tx_byte = 0x00, busy = 0, sequence = 0, overrun_count = 0, byte index = 0 and checksum = 0; a snapshot in the same cycle is ignored.

Configuration
REQ-027 Macro FRAME_CHECKSUM_EN: when defined, the CSUM state SHALL exist and the checksum byte SHALL be sent last; when undefined, the checksum logic and the CSUM state SHALL be absent and the frame SHALL end after the last DATA byte.

Verification
REQ-028 Bench parameters SHALL be NUM_INPUTS=2 (NUM_WORDS=3) and RESOLUTION=16, with FRAME_CHECKSUM_EN defined unless stated otherwise.
REQ-029 Basic frame: words 0x1234, 0xABCD, 0x0001; snapshot once; tx_ready held at 1 -> bytes AA 55 00 34 12 CD AB 01 00 BF on consecutive cycles, then tx_valid = 0 and busy = 0.
REQ-030 Backpressure: same data, tx_ready = 0 for 5 cycles during byte 0xCD -> 0xCD held stable for all 5 cycles; byte order and checksum unchanged.
REQ-031 Overrun: a snapshot in the 3rd frame cycle and another in the final-transfer cycle -> overrun_count = 2, and the first frame is unaltered.
REQ-032 Sequence wrap: send 256 frames -> the sequence byte of frame 257 is 0x00.
REQ-033 Reset mid-DATA: assert reset on the 4th byte -> tx_valid = 0 on the next cycle; the next snapshot produces a frame with sequence 0x00.
REQ-034 FRAME_CHECKSUM_EN undefined: basic-frame stimulus -> 9 bytes ending in 0x00, with no 0xBF byte.
